// File: rtl/mac_pkg.sv
// Shared definitions for the multiply-accumulate path: product width,
// accumulator state encoding and the beat-counter width helper.
package mac_pkg;

  localparam int PROD_W = 8;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  // A one-bit counter is still needed when LEN is so small that clog2 gives 0.
  function automatic int cntWidth(input int len);
    return ($clog2(len) < 1) ? 1 : $clog2(len);
  endfunction

endpackage

// File: rtl/prod_accumulator.sv
// Sums LEN unsigned products from the wallace_tree multiplier into one result
// and holds that result, with a sticky carry-out flag, until it is accepted.
module prod_accumulator
  import mac_pkg::*;
#(
  parameter int LEN   = 4,
  parameter int ACC_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf
);

  localparam int CNT_W = cntWidth(LEN);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [ACC_W-1:0]   sum_q, sum_d;
  logic               sumOvf_q, sumOvf_d;

  logic [ACC_W:0]     addFull;
  logic               beat;
  logic               lastBeat;

  // Handshake outputs come straight from the state register, so neither
  // in_valid nor out_ready reaches an output combinationally.
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign out_sum   = sum_q;
  assign out_ovf   = sumOvf_q;

  assign addFull  = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_prod};
  assign beat     = in_valid && in_ready;
  assign lastBeat = beat && (cnt_q == CNT_W'(LEN - 1));

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    sum_d    = sum_q;
    sumOvf_d = sumOvf_q;

    if (clear) begin
      state_d  = ACCUM;
      acc_d    = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
      sum_d    = '0;
      sumOvf_d = 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (lastBeat) begin
            // The final addition goes straight to the result register so the
            // accumulator is already zeroed for the next result.
            sum_d    = addFull[ACC_W-1:0];
            sumOvf_d = ovf_q | addFull[ACC_W];
            acc_d    = '0;
            cnt_d    = '0;
            ovf_d    = 1'b0;
            state_d  = HOLD;
          end else if (beat) begin
            acc_d = addFull[ACC_W-1:0];
            cnt_d = cnt_q + 1'b1;
            ovf_d = ovf_q | addFull[ACC_W];
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d = ACCUM;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ACCUM;
      acc_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      sum_q    <= '0;
      sumOvf_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      sum_q    <= sum_d;
      sumOvf_q <= sumOvf_d;
    end
  end

endmodule

// File: tb/tb_prod_accumulator.sv
// Bench for prod_accumulator: a 16-bit and a 9-bit accumulator share every
// input, so one stimulus stream checks both the normal and the wrapping sums.
module tb_prod_accumulator;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        inValid;
  logic [7:0]  inProd;
  logic        outReady;

  logic        inReady16, outValid16, outOvf16;
  logic [15:0] outSum16;
  logic        inReady9, outValid9, outOvf9;
  logic [8:0]  outSum9;

  typedef struct packed {
    logic [15:0] s16;
    logic        o16;
    logic [8:0]  s9;
    logic        o9;
  } expT;

  typedef struct packed {
    logic [3:0][7:0] prod;
    logic [3:0][1:0] gap;
    expT             res;
  } vecT;

  expT expQ[$];
  vecT vecs[6];

  int  checkCount = 0;
  int  passCount  = 0;
  bit  mHold      = 1'b0;
  int  mCnt       = 0;
  bit  beatTaken  = 1'b0;

  prod_accumulator #(.LEN(4), .ACC_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(inValid), .in_ready(inReady16), .in_prod(inProd),
    .out_valid(outValid16), .out_ready(outReady),
    .out_sum(outSum16), .out_ovf(outOvf16)
  );

  prod_accumulator #(.LEN(4), .ACC_W(9)) dut9 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(inValid), .in_ready(inReady9), .in_prod(inProd),
    .out_valid(outValid9), .out_ready(outReady),
    .out_sum(outSum9), .out_ovf(outOvf9)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic vecT mkVec(input logic [7:0] p0, p1, p2, p3,
                                input logic [1:0] g0, g1, g2, g3,
                                input logic [15:0] s16, input logic o16,
                                input logic [8:0] s9, input logic o9);
    vecT v;
    v.prod = {p3, p2, p1, p0};
    v.gap  = {g3, g2, g1, g0};
    v.res  = '{s16: s16, o16: o16, s9: s9, o9: o9};
    return v;
  endfunction

  // Reference control model plus scoreboard: handshake flags are predicted
  // every cycle and a pending result is compared while it is held.
  always @(negedge clk) begin
    if (!rst_n) begin
      mHold = 1'b0;
      mCnt  = 0;
    end else begin
      checkOutput("in_ready16",  32'(inReady16),  32'(!mHold));
      checkOutput("out_valid16", 32'(outValid16), 32'(mHold));
      checkOutput("in_ready9",   32'(inReady9),   32'(!mHold));
      checkOutput("out_valid9",  32'(outValid9),  32'(mHold));
      if (mHold) begin
        if (expQ.size() == 0) begin
          checkOutput("result queued", 32'd0, 32'd1);
        end else begin
          checkOutput("out_sum16", 32'(outSum16), 32'(expQ[0].s16));
          checkOutput("out_ovf16", 32'(outOvf16), 32'(expQ[0].o16));
          checkOutput("out_sum9",  32'(outSum9),  32'(expQ[0].s9));
          checkOutput("out_ovf9",  32'(outOvf9),  32'(expQ[0].o9));
        end
      end
      if (clear) begin
        mHold = 1'b0;
        mCnt  = 0;
        expQ.delete();
      end else if (mHold) begin
        if (outReady) begin
          if (expQ.size() != 0) void'(expQ.pop_front());
          mHold = 1'b0;
        end
      end else if (inValid) begin
        beatTaken = 1'b1;
        if (mCnt == 3) begin
          mCnt  = 0;
          mHold = 1'b1;
        end else begin
          mCnt++;
        end
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] p, input int gap);
    int n;
    inValid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    inValid   = 1'b1;
    inProd    = p;
    beatTaken = 1'b0;
    n = 0;
    while (!beatTaken && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!beatTaken) checkOutput("beat accepted in time", 32'd0, 32'd1);
  endtask

  task automatic waitDrain(input int bound);
    int n;
    inValid = 1'b0;
    n = 0;
    while ((expQ.size() != 0 || mHold) && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= bound) checkOutput("result drained in time", 32'd0, 32'd1);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " in_ready16"},  32'(inReady16),  32'd1);
    checkOutput({tag, " out_valid16"}, 32'(outValid16), 32'd0);
    checkOutput({tag, " out_sum16"},   32'(outSum16),   32'd0);
    checkOutput({tag, " out_ovf16"},   32'(outOvf16),   32'd0);
    checkOutput({tag, " in_ready9"},   32'(inReady9),   32'd1);
    checkOutput({tag, " out_valid9"},  32'(outValid9),  32'd0);
    checkOutput({tag, " out_sum9"},    32'(outSum9),    32'd0);
    checkOutput({tag, " out_ovf9"},    32'(outOvf9),    32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    clear    = 1'b0;
    inValid  = 1'b0;
    inProd   = 8'd0;
    outReady = 1'b1;

    vecs[0] = mkVec(225, 225, 225, 225, 0, 0, 0, 0, 16'd900,  1'b0, 9'd388, 1'b1);
    vecs[1] = mkVec(1,   2,   3,   4,   0, 0, 0, 0, 16'd10,   1'b0, 9'd10,  1'b0);
    vecs[2] = mkVec(10,  20,  30,  40,  0, 2, 0, 1, 16'd100,  1'b0, 9'd100, 1'b0);
    vecs[3] = mkVec(0,   0,   0,   0,   0, 0, 0, 0, 16'd0,    1'b0, 9'd0,   1'b0);
    vecs[4] = mkVec(255, 255, 255, 255, 0, 0, 0, 0, 16'd1020, 1'b0, 9'd508, 1'b1);
    vecs[5] = mkVec(200, 100, 0,   255, 0, 0, 0, 0, 16'd555,  1'b0, 9'd43,  1'b1);

    #3;
    checkResetValues("reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] table vectors, out_ready held high");
    for (int v = 0; v < 6; v++) begin
      expQ.push_back(vecs[v].res);
      for (int k = 0; k < 4; k++) applyStimulus(vecs[v].prod[k], int'(vecs[v].gap[k]));
    end
    waitDrain(50);

    $display("[TB] backpressure with a product waiting upstream");
    outReady = 1'b0;
    expQ.push_back('{s16: 16'd26, o16: 1'b0, s9: 9'd26, o9: 1'b0});
    applyStimulus(5, 0);
    applyStimulus(6, 0);
    applyStimulus(7, 0);
    applyStimulus(8, 0);
    expQ.push_back('{s16: 16'd10, o16: 1'b0, s9: 9'd10, o9: 1'b0});
    inProd    = 8'd7;
    beatTaken = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    outReady = 1'b1;
    for (int n = 0; n < 10 && !beatTaken; n++) begin @(posedge clk); #1; end
    applyStimulus(1, 0);
    applyStimulus(1, 0);
    applyStimulus(1, 0);
    waitDrain(50);

    $display("[TB] clear during accumulation");
    applyStimulus(50, 0);
    applyStimulus(60, 0);
    clear   = 1'b1;
    inValid = 1'b1;
    inProd  = 8'd99;
    @(posedge clk); #1;
    clear   = 1'b0;
    inValid = 1'b0;
    expQ.push_back('{s16: 16'd10, o16: 1'b0, s9: 9'd10, o9: 1'b0});
    for (int k = 1; k <= 4; k++) applyStimulus(8'(k), 0);
    waitDrain(50);

    $display("[TB] clear while a result is held");
    outReady = 1'b0;
    expQ.push_back('{s16: 16'd100, o16: 1'b0, s9: 9'd100, o9: 1'b0});
    for (int k = 1; k <= 4; k++) applyStimulus(8'(10 * k), 0);
    inValid = 1'b0;
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk);
    checkOutput("out_sum16 after clear", 32'(outSum16), 32'd0);
    checkOutput("out_sum9 after clear",  32'(outSum9),  32'd0);
    @(posedge clk); #1;
    outReady = 1'b1;

    $display("[TB] asynchronous reset mid-accumulation");
    applyStimulus(225, 0);
    applyStimulus(75, 0);
    inValid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkResetValues("async reset");
    expQ.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    expQ.push_back('{s16: 16'd4, o16: 1'b0, s9: 9'd4, o9: 1'b0});
    for (int k = 0; k < 4; k++) applyStimulus(1, 0);
    waitDrain(50);

    repeat (2) @(posedge clk);
    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
